// File: rtl/asm.sv
// 4x4 matrix multiplier: loads A then B from a byte stream, runs an output-stationary
// systolic array, then streams C row-major. Define ASM_SIGNED_EN for two's-complement math.
module asm #(
  parameter int DW = 8,
  parameter int CW = 18
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RxD_data_in_ready,
  input  logic [DW-1:0] RxD_data_in,
  output logic          load_ready,
  output logic          data_valid_out,
  output logic [CW-1:0] c_data,
  output logic [1:0]    c_row,
  output logic [1:0]    c_col
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t        state, state_nxt;
  logic [4:0]    byte_cnt;
  logic [3:0]    step;
  logic [3:0]    idx;
  logic [DW-1:0] a_mat [16];
  logic [DW-1:0] b_mat [16];
  logic [DW-1:0] a_feed [4];
  logic [DW-1:0] b_feed [4];
  logic [DW-1:0] a_pipe [4][4];
  logic [DW-1:0] b_pipe [4][4];
  logic [CW-1:0] acc [4][4];
  logic          start;
  logic          computing;

  assign start     = (state == LOAD) && RxD_data_in_ready && (byte_cnt == 5'd31);
  assign computing = (state == COMPUTE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_ready     = 1'b0;
    data_valid_out = 1'b0;
    c_row          = idx[3:2];
    c_col          = idx[1:0];
    c_data         = '0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        if (start) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        if (step == 4'd9) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        data_valid_out = 1'b1;
        c_data         = acc[idx[3:2]][idx[1:0]];
        if (idx == 4'd15) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Byte, step and output-index counters; idx and byte_cnt wrap back to 0 naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_cnt <= '0;
      step     <= '0;
      idx      <= '0;
    end else begin
      if (state == LOAD && RxD_data_in_ready) byte_cnt <= byte_cnt + 5'd1;
      if (start)                              step <= '0;
      else if (computing)                     step <= (step == 4'd9) ? 4'd0 : step + 4'd1;
      if (state == OUTPUT)                    idx <= idx + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) begin
        a_mat[i] <= '0;
        b_mat[i] <= '0;
      end
    end else if (state == LOAD && RxD_data_in_ready) begin
      if (!byte_cnt[4]) a_mat[byte_cnt[3:0]] <= RxD_data_in;
      else              b_mat[byte_cnt[3:0]] <= RxD_data_in;
    end
  end

  // Skewed edge feeds: row i sees A[i][step-i], column j sees B[step-j][j].
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
      if (computing && step >= 4'(i) && (step - 4'(i)) < 4'd4) begin
        a_feed[i] = a_mat[{2'(i), 2'(step - 4'(i))}];
        b_feed[i] = b_mat[{2'(step - 4'(i)), 2'(i)}];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_col
      logic [DW-1:0] a_in, b_in, a_q, b_q;
      logic [CW-1:0] a_ext, b_ext, prod, acc_q;

      if (gj == 0) begin : g_left
        assign a_in = a_feed[gi];
      end else begin : g_inner_a
        assign a_in = a_pipe[gi][gj-1];
      end

      if (gi == 0) begin : g_top
        assign b_in = b_feed[gj];
      end else begin : g_inner_b
        assign b_in = b_pipe[gi-1][gj];
      end

`ifdef ASM_SIGNED_EN
      assign a_ext = {{(CW-DW){a_in[DW-1]}}, a_in};
      assign b_ext = {{(CW-DW){b_in[DW-1]}}, b_in};
`else
      assign a_ext = {{(CW-DW){1'b0}}, a_in};
      assign b_ext = {{(CW-DW){1'b0}}, b_in};
`endif
      assign prod = a_ext * b_ext;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (start) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (computing) begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= acc_q + prod;
        end
      end

      assign a_pipe[gi][gj] = a_q;
      assign b_pipe[gi][gj] = b_q;
      assign acc[gi][gj]    = acc_q;
    end
  end

endmodule

// File: tb/tb_asm.sv
// Self-checking bench for asm: directed and random matrix loads compared against a
// plain matrix-product model; honours ASM_SIGNED_EN.
module tb_asm;

  localparam int DW = 8;
  localparam int CW = 18;

  typedef logic [7:0] bytes_t [32];

  logic          clk;
  logic          rst_n;
  logic          rxReady;
  logic [DW-1:0] rxData;
  logic          load_ready;
  logic          data_valid_out;
  logic [CW-1:0] c_data;
  logic [1:0]    c_row;
  logic [1:0]    c_col;

  int testCount = 0;
  int failCount = 0;

  asm #(.DW(DW), .CW(CW)) dut (
    .CLK               (clk),
    .RST_N             (rst_n),
    .RxD_data_in_ready (rxReady),
    .RxD_data_in       (rxData),
    .load_ready        (load_ready),
    .data_valid_out    (data_valid_out),
    .c_data            (c_data),
    .c_row             (c_row),
    .c_col             (c_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // C[r][c] = sum_k A[r][k]*B[k][c], computed directly from the byte order.
  function automatic logic [31:0] refElem(input bytes_t b, input int r, input int c);
    longint s = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef ASM_SIGNED_EN
      s += longint'($signed(b[r*4+k])) * longint'($signed(b[16+k*4+c]));
`else
      s += longint'(b[r*4+k]) * longint'(b[16+k*4+c]);
`endif
    end
    return 32'(s) & 32'h3FFFF;
  endfunction

  // Sends 32 bytes starting at a negedge; gap idle cycles between strobes.
  task automatic applyStimulus(input bytes_t b, input int gap, input bit holdHigh);
    for (int k = 0; k < 32; k++) begin
      if (k > 0 && gap > 0) begin
        rxReady = 1'b0;
        repeat (gap) @(negedge clk);
      end
      rxReady = 1'b1;
      rxData  = b[k];
      @(negedge clk);
    end
    if (holdHigh) rxData = 8'hAA;
    else          rxReady = 1'b0;
  endtask

  // expMode 0: model, 1: constant constVal, 2: identity product (idx+1).
  task automatic checkOutput(input bytes_t b, input int expMode, input int constVal);
    int cnt = 0;
    logic [31:0] exp;
    compare("load_ready_low_after_load", 32'(load_ready), 32'd0);
    while (!data_valid_out && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    compare("valid_within_bound", 32'(cnt < 200), 32'd1);
    compare("compute_latency", 32'(cnt), 32'd10);
    for (int i = 0; i < 16; i++) begin
      case (expMode)
        1:       exp = 32'(constVal);
        2:       exp = 32'(i + 1);
        default: exp = refElem(b, i / 4, i % 4);
      endcase
      compare("valid", 32'(data_valid_out), 32'd1);
      compare("c_row", 32'(c_row), 32'(i / 4));
      compare("c_col", 32'(c_col), 32'(i % 4));
      compare("c_data", 32'(c_data), exp);
      @(negedge clk);
    end
    compare("valid_low_after_16", 32'(data_valid_out), 32'd0);
    compare("load_ready_back", 32'(load_ready), 32'd1);
  endtask

  function automatic bytes_t randBytes();
    bytes_t b;
    for (int k = 0; k < 32; k++) b[k] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  initial begin
    bytes_t cur;
    rst_n   = 1'b0;
    rxReady = 1'b0;
    rxData  = '0;
    repeat (2) @(negedge clk);
    compare("reset_load_ready", 32'(load_ready), 32'd1);
    compare("reset_valid", 32'(data_valid_out), 32'd0);
    compare("reset_c_data", 32'(c_data), 32'd0);
    compare("reset_c_rowcol", 32'({c_row, c_col}), 32'd0);
    rst_n = 1'b1;

    $display("[TB] all-ones load");
    for (int k = 0; k < 32; k++) cur[k] = 8'h01;
    applyStimulus(cur, 0, 1'b0);
    checkOutput(cur, 1, 4);

    $display("[TB] identity times ramp");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cur[i*4+j]    = (i == j) ? 8'd1 : 8'd0;
        cur[16+i*4+j] = 8'(i*4 + j + 1);
      end
    applyStimulus(cur, 0, 1'b0);
    checkOutput(cur, 2, 0);

    $display("[TB] max operands");
    for (int k = 0; k < 32; k++) cur[k] = 8'hFF;
    applyStimulus(cur, 0, 1'b0);
`ifdef ASM_SIGNED_EN
    checkOutput(cur, 1, 4);
`else
    checkOutput(cur, 1, 260100);
`endif

    $display("[TB] random contiguous loads");
    for (int n = 0; n < 3; n++) begin
      cur = randBytes();
      applyStimulus(cur, 0, 1'b0);
      checkOutput(cur, 0, 0);
    end

    $display("[TB] gapped strobe");
    cur = randBytes();
    applyStimulus(cur, 2, 1'b0);
    checkOutput(cur, 0, 0);

    $display("[TB] strobe held through compute and output");
    cur = randBytes();
    applyStimulus(cur, 0, 1'b1);
    checkOutput(cur, 0, 0);
    cur = randBytes();
    applyStimulus(cur, 0, 1'b0);
    checkOutput(cur, 0, 0);

    $display("[TB] reset during compute");
    cur = randBytes();
    applyStimulus(cur, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare("midreset_load_ready", 32'(load_ready), 32'd1);
    compare("midreset_valid", 32'(data_valid_out), 32'd0);
    compare("midreset_c_data", 32'(c_data), 32'd0);
    @(negedge clk);
    compare("midreset_hold_valid", 32'(data_valid_out), 32'd0);
    rst_n = 1'b1;
    cur = randBytes();
    applyStimulus(cur, 0, 1'b0);
    checkOutput(cur, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
